// File: rtl/sm83_bus_pkg.sv
// Shared constants for the SM83 external-bus responder: register addresses,
// interrupt bit indices and address-region decode values.
package sm83_bus_pkg;

    localparam logic [15:0] DEF_IF_ADDR   = 16'hFF0F;
    localparam logic [15:0] DEF_BOOT_ADDR = 16'hFF50;
    localparam int          DEF_NUM_IRQ   = 5;

    localparam int VBLANK = 0;
    localparam int STAT   = 1;
    localparam int TIMER  = 2;
    localparam int SERIAL = 3;
    localparam int JOYPAD = 4;

    localparam logic [6:0] MMIO_HI = 7'h7F;
    localparam logic [7:0] IPL_HI  = 8'h00;

endpackage

// File: rtl/sm83_if_bit.sv
// One interrupt-flag bit: rising-edge detect on its source, then
// set > write > clear priority so a coincident request is never lost.
module sm83_if_bit (
    input  logic CLK,
    input  logic nRESET,
    input  logic src,
    input  logic ack,
    input  logic wr,
    input  logic wdata,
    output logic flag,
    output logic set_pulse
);

    logic src_prev_q, src_prev_d;
    logic flag_q, flag_d;

    assign set_pulse = src & ~src_prev_q;

    always_comb begin
        src_prev_d = src;
        if (set_pulse)
            flag_d = 1'b1;
        else if (wr)
            flag_d = wdata;
        else if (ack)
            flag_d = 1'b0;
        else
            flag_d = flag_q;
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            src_prev_q <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            src_prev_q <= src_prev_d;
            flag_q     <= flag_d;
        end
    end

    assign flag = flag_q;

endmodule

// File: rtl/sm83_bus_responder.sv
// System-side responder on the SM83 external bus: region decode, IF and
// boot-lock registers, interrupt trigger/ack handling and STOP wake pulse.
module sm83_bus_responder
    import sm83_bus_pkg::*;
#(
    parameter logic [15:0] IF_ADDR   = DEF_IF_ADDR,
    parameter logic [15:0] BOOT_ADDR = DEF_BOOT_ADDR,
    parameter int          NUM_IRQ   = DEF_NUM_IRQ
) (
    input  logic               CLK,
    input  logic               nRESET,
    input  logic [15:0]        A,
    input  logic               RD,
    input  logic               WR,
    input  logic [7:0]         DI,
    output logic [7:0]         DO,
    output logic               DOE,
    output logic               MMIO_REQ,
    output logic               IPL_REQ,
    input  logic [NUM_IRQ-1:0] IRQ_SRC,
    output logic [7:0]         CPU_IRQ_TRIG,
    input  logic [7:0]         CPU_IRQ_ACK,
    output logic               WAKE
);

    logic wr_prev_q, wr_prev_d;
    logic boot_off_q, boot_off_d;
    logic wake_q, wake_d;

    logic               wr_edge;
    logic               sel_if;
    logic               sel_boot;
    logic [NUM_IRQ-1:0] if_q;
    logic [NUM_IRQ-1:0] set_vec;

    wire unused_ok = ^{CPU_IRQ_ACK[7:NUM_IRQ], DI[7:NUM_IRQ]};

    assign sel_if   = (A == IF_ADDR);
    assign sel_boot = (A == BOOT_ADDR);
    // A strobe held for several cycles commits only on its first edge.
    assign wr_edge  = WR & ~wr_prev_q;

    assign MMIO_REQ = (A[15:9] == MMIO_HI);
    assign IPL_REQ  = (A[15:8] == IPL_HI) & ~boot_off_q;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_if
        sm83_if_bit u_bit (
            .CLK       (CLK),
            .nRESET    (nRESET),
            .src       (IRQ_SRC[i]),
            .ack       (CPU_IRQ_ACK[i]),
            .wr        (wr_edge & sel_if),
            .wdata     (DI[i]),
            .flag      (if_q[i]),
            .set_pulse (set_vec[i])
        );
    end

    always_comb begin
        wr_prev_d  = WR;
        boot_off_d = boot_off_q | (wr_edge & sel_boot & DI[0]);
        wake_d     = set_vec[JOYPAD];
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            wr_prev_q  <= 1'b0;
            boot_off_q <= 1'b0;
            wake_q     <= 1'b0;
        end else begin
            wr_prev_q  <= wr_prev_d;
            boot_off_q <= boot_off_d;
            wake_q     <= wake_d;
        end
    end

    always_comb begin
        DOE = RD & (sel_if | sel_boot);
        if (sel_if)
            DO = {{(8-NUM_IRQ){1'b1}}, if_q};
        else if (sel_boot)
            DO = {7'h7F, boot_off_q};
        else
            DO = 8'hFF;
    end

    assign CPU_IRQ_TRIG = {{(8-NUM_IRQ){1'b0}}, if_q};
    assign WAKE         = wake_q;

endmodule

// File: tb/tb_sm83_bus_responder.sv
// Bench for sm83_bus_responder: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_sm83_bus_responder;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic [15:0] A;
    logic        RD, WR;
    logic [7:0]  DI;
    logic [7:0]  DO;
    logic        DOE, MMIO_REQ, IPL_REQ, WAKE;
    logic [4:0]  IRQ_SRC;
    logic [7:0]  CPU_IRQ_TRIG;
    logic [7:0]  CPU_IRQ_ACK;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    sm83_bus_responder dut (
        .CLK          (CLK),
        .nRESET       (nRESET),
        .A            (A),
        .RD           (RD),
        .WR           (WR),
        .DI           (DI),
        .DO           (DO),
        .DOE          (DOE),
        .MMIO_REQ     (MMIO_REQ),
        .IPL_REQ      (IPL_REQ),
        .IRQ_SRC      (IRQ_SRC),
        .CPU_IRQ_TRIG (CPU_IRQ_TRIG),
        .CPU_IRQ_ACK  (CPU_IRQ_ACK),
        .WAKE         (WAKE)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: flags, boot lock and previous-cycle samples.
    logic [7:0] m_if;
    logic       m_boot;
    logic [4:0] m_src_prev;
    logic       m_wr_prev;
    logic       m_wake;

    always @(posedge CLK or negedge nRESET) begin
        logic [4:0] rises;
        logic [7:0] nxt;
        logic       commit;
        if (!nRESET) begin
            m_if = 8'h00; m_boot = 1'b0; m_src_prev = 5'h00;
            m_wr_prev = 1'b0; m_wake = 1'b0;
        end else begin
            rises  = IRQ_SRC & ~m_src_prev;
            commit = WR && !m_wr_prev;
            nxt    = m_if & ~CPU_IRQ_ACK;
            if (commit && A == 16'hFF0F) nxt = DI;
            nxt    = (nxt | {3'b000, rises}) & 8'h1F;
            m_if   = nxt;
            if (commit && A == 16'hFF50 && DI[0]) m_boot = 1'b1;
            m_wake     = rises[4];
            m_src_prev = IRQ_SRC;
            m_wr_prev  = WR;
        end
    end

    always @(negedge CLK) begin
        logic [7:0] e_do;
        logic       e_doe;
        if (A == 16'hFF0F)      e_do = 8'hE0 | m_if;
        else if (A == 16'hFF50) e_do = 8'hFE | {7'h00, m_boot};
        else                    e_do = 8'hFF;
        e_doe = RD && (A == 16'hFF0F || A == 16'hFF50);
        chk("m_trig", {8'h00, CPU_IRQ_TRIG}, {8'h00, m_if});
        chk("m_wake", {15'h0, WAKE}, {15'h0, m_wake});
        chk("m_mmio", {15'h0, MMIO_REQ}, {15'h0, A >= 16'hFE00});
        chk("m_ipl",  {15'h0, IPL_REQ}, {15'h0, (A < 16'h0100) && !m_boot});
        chk("m_doe",  {15'h0, DOE}, {15'h0, e_doe});
        if (e_doe) chk("m_do", {8'h00, DO}, {8'h00, e_do});
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRESET = 1'b0; A = 16'h0000; RD = 1'b0; WR = 1'b0; DI = 8'h00;
        IRQ_SRC = 5'h00; CPU_IRQ_ACK = 8'h00;
        #1;
        chk("rst_trig", {8'h00, CPU_IRQ_TRIG}, 16'h0000);
        chk("rst_wake", {15'h0, WAKE}, 16'h0000);
        tick();
        nRESET = 1'b1;
        A = 16'h0012; #1;
        chk("ipl_0012", {14'h0, IPL_REQ, MMIO_REQ}, 16'h0002);
        A = 16'hFF44; #1;
        chk("mmio_ff44", {14'h0, IPL_REQ, MMIO_REQ}, 16'h0001);
        A = 16'hFE00; #1;
        chk("mmio_fe00", {15'h0, MMIO_REQ}, 16'h0001);

        tick();
        A = 16'hFF50; DI = 8'h01; WR = 1'b1;
        tick();
        RD = 1'b1; #1;
        chk("boot_rd", {7'h0, DOE, DO}, 16'h01FF);
        tick(); tick();
        WR = 1'b0; RD = 1'b0; A = 16'h0012; #1;
        chk("ipl_off", {15'h0, IPL_REQ}, 16'h0000);
        tick();
        A = 16'hFF50; DI = 8'h00; WR = 1'b1;
        tick();
        WR = 1'b0; RD = 1'b1; #1;
        chk("boot_sticky", {8'h00, DO}, 16'h00FF);
        RD = 1'b0; A = 16'h0012; #1;
        chk("ipl_still_off", {15'h0, IPL_REQ}, 16'h0000);

        tick();
        A = 16'h0000; IRQ_SRC = 5'h04;
        tick();
        chk("timer_set", {8'h00, CPU_IRQ_TRIG}, 16'h0004);
        repeat (9) tick();
        chk("timer_noretrig", {8'h00, CPU_IRQ_TRIG}, 16'h0004);
        CPU_IRQ_ACK = 8'h04;
        tick();
        CPU_IRQ_ACK = 8'h00; #1;
        chk("timer_ack", {8'h00, CPU_IRQ_TRIG}, 16'h0000);
        A = 16'hFF0F; RD = 1'b1; #1;
        chk("if_rd_e0", {7'h0, DOE, DO}, 16'h01E0);
        RD = 1'b0;

        tick();
        IRQ_SRC = 5'h01; CPU_IRQ_ACK = 8'h01;
        tick();
        CPU_IRQ_ACK = 8'h00; #1;
        chk("set_beats_ack", {8'h00, CPU_IRQ_TRIG}, 16'h0001);
        IRQ_SRC = 5'h03; A = 16'hFF0F; DI = 8'h00; WR = 1'b1;
        tick();
        WR = 1'b0; #1;
        chk("set_beats_wr0", {8'h00, CPU_IRQ_TRIG}, 16'h0002);

        tick();
        DI = 8'hFF; WR = 1'b1;
        tick();
        WR = 1'b0; RD = 1'b1; #1;
        chk("wr_ff_trig", {8'h00, CPU_IRQ_TRIG}, 16'h001F);
        chk("wr_ff_rd", {8'h00, DO}, 16'h00FF);
        RD = 1'b0;
        CPU_IRQ_ACK = 8'h18;
        tick();
        CPU_IRQ_ACK = 8'h00; #1;
        chk("multi_ack", {8'h00, CPU_IRQ_TRIG}, 16'h0007);

        IRQ_SRC = 5'h10;
        tick();
        chk("wake_hi", {7'h0, WAKE, CPU_IRQ_TRIG}, 16'h0117);
        tick();
        chk("wake_lo", {7'h0, WAKE, CPU_IRQ_TRIG}, 16'h0017);
        IRQ_SRC = 5'h00;
        tick();
        IRQ_SRC = 5'h10;
        tick();
        chk("wake_hi2", {15'h0, WAKE}, 16'h0001);
        #1 nRESET = 1'b0;
        #1;
        chk("midrst", {7'h0, WAKE, CPU_IRQ_TRIG}, 16'h0000);
        A = 16'h0012; #1;
        chk("midrst_ipl", {15'h0, IPL_REQ}, 16'h0001);

        A = 16'hFF50; DI = 8'h01; WR = 1'b1; IRQ_SRC = 5'h00;
        #1 nRESET = 1'b1;
        tick();
        WR = 1'b0; A = 16'h0012; #1;
        chk("wr_across_rst", {15'h0, IPL_REQ}, 16'h0000);

        for (int n = 0; n < 2500; n++) begin
            tick();
            case ($urandom_range(0, 5))
                0: A = 16'hFF0F;
                1: A = 16'hFF50;
                2: A = 16'h00FF & 16'($urandom);
                3: A = 16'hFE00 | 16'($urandom_range(0, 511));
                4: A = 16'hFF0F;
                default: A = 16'($urandom);
            endcase
            RD = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) == 0) WR = ~WR;
            DI = 8'($urandom);
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 7) == 0) IRQ_SRC[b] = ~IRQ_SRC[b];
            case ($urandom_range(0, 7))
                0: CPU_IRQ_ACK = 8'h01 << $urandom_range(0, 7);
                1: CPU_IRQ_ACK = 8'($urandom);
                default: CPU_IRQ_ACK = 8'h00;
            endcase
            if ($urandom_range(0, 299) == 0) begin
                nRESET = 1'b0;
                #2 nRESET = 1'b1;
            end
        end

        WR = 1'b0; RD = 1'b0; CPU_IRQ_ACK = 8'h00;
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
